// File: rtl/spart_if.sv
// Processor-side SPART bus: select, direction, register address and the status lines back to the driver.
// The data bus itself is a bidirectional wire carried as a separate inout port.
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_core.sv
// SPART register responder: bus decode, baud divisor, 8N1 transmitter and 16x-oversampled receiver.
// Define SPART_ERR_FLAGS_EN to build sticky framing-error / overrun flags into status[3:2].
module spart_core #(
    parameter logic [15:0] DB_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    spart_if.slave     bus,
    inout  wire  [7:0] databus,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic        rd, wr, rx_rd, st_rd;
    logic [7:0]  rd_dat, status, rx_buf;
    logic [15:0] db, baud_cnt;
    logic        tick, tbr, rda, ovr, fe;

    assign rd    = bus.iocs & bus.iorw;
    assign wr    = bus.iocs & ~bus.iorw;
    assign rx_rd = rd && bus.ioaddr == 2'b00;
    assign st_rd = rd && bus.ioaddr == 2'b01;

    assign status  = {4'b0000, ovr, fe, tbr, rda};
    assign databus = rd ? rd_dat : 8'bz;
    assign bus.rda = rda;
    assign bus.tbr = tbr;

    always_comb begin
        rd_dat = rx_buf;
        case (bus.ioaddr)
            2'b00:   rd_dat = rx_buf;
            2'b01:   rd_dat = status;
            2'b10:   rd_dat = db[7:0];
            default: rd_dat = db[15:8];
        endcase
    end

    // A divisor write restarts the count so the new rate applies from the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db       <= DB_RESET;
            baud_cnt <= DB_RESET;
        end else if (wr && bus.ioaddr == 2'b10) begin
            db[7:0]  <= databus;
            baud_cnt <= {db[15:8], databus};
        end else if (wr && bus.ioaddr == 2'b11) begin
            db[15:8] <= databus;
            baud_cnt <= {databus, db[7:0]};
        end else if (baud_cnt == 16'd0) begin
            baud_cnt <= db;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    assign tick = (baud_cnt == 16'd0);

    // ---------------- transmitter ----------------
    state_t     tx_st, tx_nxt;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_idx;
    logic [7:0] tx_sh;
    logic       tx_load, tx_adv;

    assign tx_load = wr && bus.ioaddr == 2'b00 && tx_st == IDLE;
    assign tx_adv  = tick && tx_tcnt == 4'd15;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st   <= IDLE;
            tx_tcnt <= 4'd0;
            tx_idx  <= 3'd0;
            tx_sh   <= 8'h00;
        end else begin
            tx_st <= tx_nxt;
            if (tx_nxt != tx_st)
                tx_tcnt <= 4'd0;
            else if (tick)
                tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_load) begin
                tx_sh  <= databus;
                tx_idx <= 3'd0;
            end else if (tx_st == DATA && tx_adv) begin
                tx_idx <= tx_idx + 3'd1;
            end
        end
    end

    always_comb begin
        tx_nxt = tx_st;
        case (tx_st)
            IDLE:    if (tx_load) tx_nxt = START;
            START:   if (tx_adv) tx_nxt = DATA;
            DATA:    if (tx_adv && tx_idx == 3'd7) tx_nxt = STOP;
            default: if (tx_adv) tx_nxt = IDLE;
        endcase
    end

    always_comb begin
        tbr = (tx_st == IDLE);
        case (tx_st)
            START:   txd = 1'b0;
            DATA:    txd = tx_sh[tx_idx];
            default: txd = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    state_t     rx_st, rx_nxt;
    logic       rx_s1, rx_s2;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_idx;
    logic [7:0] rx_sh;
    logic       rx_adv, stop_ok, stop_bad;

    assign rx_adv = tick && rx_tcnt == 4'd15;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_st   <= IDLE;
            rx_tcnt <= 4'd0;
            rx_idx  <= 3'd0;
            rx_sh   <= 8'h00;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_st <= rx_nxt;
            if (rx_nxt != rx_st)
                rx_tcnt <= 4'd0;
            else if (tick)
                rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_st == START)
                rx_idx <= 3'd0;
            else if (rx_st == DATA && rx_adv) begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_idx <= rx_idx + 3'd1;
            end
        end
    end

    // Start bit is re-checked mid-bit (8th tick) to reject short glitches.
    always_comb begin
        rx_nxt = rx_st;
        case (rx_st)
            IDLE:    if (!rx_s2) rx_nxt = START;
            START:   if (tick && rx_tcnt == 4'd7) rx_nxt = rx_s2 ? IDLE : DATA;
            DATA:    if (rx_adv && rx_idx == 3'd7) rx_nxt = STOP;
            default: if (rx_adv) rx_nxt = IDLE;
        endcase
    end

    always_comb begin
        stop_ok  = (rx_st == STOP) && rx_adv && rx_s2;
        stop_bad = (rx_st == STOP) && rx_adv && !rx_s2;
    end

    // A completing byte beats a same-edge host read, so rda stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rda    <= 1'b0;
            rx_buf <= 8'h00;
        end else if (stop_ok) begin
            rda    <= 1'b1;
            rx_buf <= rx_sh;
        end else if (rx_rd) begin
            rda    <= 1'b0;
        end
    end

`ifdef SPART_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe  <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (stop_bad)
                fe <= 1'b1;
            else if (st_rd)
                fe <= 1'b0;
            if (stop_ok && rda)
                ovr <= 1'b1;
            else if (st_rd)
                ovr <= 1'b0;
        end
    end
`else
    assign fe  = 1'b0;
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_spart_core.sv
// Scoreboarded bench for spart_core: reads push expected bytes, a monitor checks them on the read strobe.
module tb_spart_core;
`ifdef SPART_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;
    logic [7:0] tb_dat;
    wire  [7:0] databus;

    spart_if bus ();

    spart_core dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    assign databus = (bus.iocs && bus.iorw) ? 8'bz : tb_dat;

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t rdq[$];
    logic txq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk) begin
        if (!rst && bus.iocs && bus.iorw) begin
            n_tests++;
            if (rdq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %02h, no expectation queued", databus);
            end else begin
                exp_t e;
                e = rdq.pop_front();
                if (databus !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %02h expected %02h", e.name, databus, e.val);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (txq.size() > 0) begin
            logic b;
            b = txq.pop_front();
            n_tests++;
            if (txd !== b) begin
                n_fail++;
                $display("FAIL txd_bit (%0d left): got %b expected %b", txq.size(), txd, b);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
        exp_t e;
        e.name = nm;
        e.val  = exp;
        rdq.push_back(e);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        step(1);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; tb_dat = d;
        step(1);
        bus.iocs = 1'b0; tb_dat = 8'h5A;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            step(16);
        end
        rxd = stop;
        step(16);
        rxd = 1'b1;
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a5;
        rst = 1'b1; rxd = 1'b1; tb_dat = 8'h5A;
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
        step(3);
        rst = 1'b0;

        @(negedge clk);
        chk("rst_txd", 8'(txd), 8'h01);
        chk("rst_tbr", 8'(bus.tbr), 8'h01);
        chk("rst_rda", 8'(bus.rda), 8'h00);
        chk("bus_not_driven", databus, 8'h5A);
        step(1);
        bus_read(2'b01, 8'h02, "rst_status");
        bus_read(2'b10, 8'h45, "rst_db_lo");
        bus_read(2'b11, 8'h01, "rst_db_hi");
        bus_read(2'b00, 8'h00, "rst_rx_buf");

        // Transmit 0xA5 at one tick per clock; a second write mid-frame must be ignored.
        bus_write(2'b10, 8'h00);
        bus_write(2'b11, 8'h00);
        bus_read(2'b10, 8'h00, "db_lo_zero");
        a5 = 8'hA5;
        bus_write(2'b00, a5);
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < 16; k++)
                txq.push_back(b == 0 ? 1'b0 : (b == 9 ? 1'b1 : a5[b-1]));
        @(negedge clk);
        chk("tbr_drop", 8'(bus.tbr), 8'h00);
        step(39);
        bus_write(2'b00, 8'hFF);
        repeat (119) @(posedge clk);
        @(negedge clk);
        chk("tbr_busy_end", 8'(bus.tbr), 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("tbr_rise", 8'(bus.tbr), 8'h01);
        step(1);

        // Receive path.
        send_rx(8'h3C, 1'b1);
        @(negedge clk);
        chk("rda_set", 8'(bus.rda), 8'h01);
        step(1);
        bus_read(2'b00, 8'h3C, "rx_3c");
        @(negedge clk);
        chk("rda_clear", 8'(bus.rda), 8'h00);
        step(1);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        @(negedge clk);
        chk("rda_overrun", 8'(bus.rda), 8'h01);
        step(1);
        bus_write(2'b00, 8'h55);
        bus_read(2'b01, ERR ? 8'h09 : 8'h01, "status_ovr");
        bus_read(2'b01, 8'h01, "status_ovr_reread");
        bus_read(2'b00, 8'h22, "rx_overwrite");

        send_rx(8'h77, 1'b0);
        @(negedge clk);
        chk("rda_after_fe", 8'(bus.rda), 8'h00);
        step(1);
        bus_read(2'b01, ERR ? 8'h06 : 8'h02, "status_fe");
        bus_read(2'b01, 8'h02, "status_fe_reread");
        bus_read(2'b00, 8'h22, "rx_fe_discard");

        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(200);
        chk("rda_glitch", 8'(bus.rda), 8'h00);
        bus_read(2'b00, 8'h22, "rx_glitch");
        send_rx(8'h81, 1'b1);
        bus_read(2'b00, 8'h81, "rx_after_glitch");

        // Reset in the middle of a transmit frame.
        bus_write(2'b00, 8'h00);
        step(30);
        chk("tx_midframe", 8'(txd), 8'h00);
        rst = 1'b1;
        #2;
        chk("rst_mid_txd", 8'(txd), 8'h01);
        chk("rst_mid_tbr", 8'(bus.tbr), 8'h01);
        step(1);
        rst = 1'b0;
        step(1);
        bus_read(2'b10, 8'h45, "db_lo_after_rst");
        bus_read(2'b01, 8'h02, "status_after_rst");

        step(2);
        chk("scoreboard_drained", 8'(rdq.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
